// File: rtl/counter_checker_if.sv
// Observed counter bus: the counter's control inputs plus its q/c outputs, as seen by a passive checker.
interface counter_checker_if #(
  parameter int W = 4
);
  logic         m_cl;
  logic         m_en;
  logic         m_ud;
  logic [W-1:0] m_q;
  logic         m_c;

  modport master (output m_cl, m_en, m_ud, m_q, m_c);
  modport slave  (input  m_cl, m_en, m_ud, m_q, m_c);
endinterface

// File: rtl/counter_checker.sv
// Passive up/down counter checker: reference model tracks the observed counter and counts mismatches.
// Optional realignment of the model on mismatch: define COUNTER_CHECKER_RESYNC_EN.
module counter_checker #(
  parameter int W  = 4,
  parameter int EW = 8
) (
  input  logic                   ck,
  input  logic                   cl,
  counter_checker_if.slave       mon,
  output logic                   synced,
  output logic                   mism,
  output logic                   fail,
  output logic [EW-1:0]          err_cnt,
  output logic [W-1:0]           exp_q
);

  typedef enum logic [0:0] {UNSYNC, TRACK} state_t;

  state_t        state_q,   state_d;
  logic          synced_q,  synced_d;
  logic          mism_q,    mism_d;
  logic          fail_q,    fail_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]  exp_q_q,   exp_q_d;

  logic          exp_c;
  logic          mismatch;

  // Counter next-state rule shared by the model and the realign path.
  function automatic logic [W-1:0] next_count(input logic [W-1:0] cur,
                                              input logic clr, input logic en,
                                              input logic ud);
    if (clr)
      return '0;
    else if (en)
      return ud ? cur - W'(1) : cur + W'(1);
    else
      return cur;
  endfunction

  always_comb begin
    state_d   = state_q;
    synced_d  = synced_q;
    mism_d    = 1'b0;
    fail_d    = fail_q;
    err_cnt_d = err_cnt_q;
    exp_q_d   = exp_q_q;

    exp_c    = mon.m_en & (mon.m_ud ? (exp_q_q == '0) : (exp_q_q == '1));
    mismatch = (mon.m_q != exp_q_q) | (mon.m_c != exp_c);

    case (state_q)
      UNSYNC: begin
        if (mon.m_cl) begin
          exp_q_d  = '0;
          state_d  = TRACK;
          synced_d = 1'b1;
        end
      end
      TRACK: begin
        mism_d  = mismatch;
        exp_q_d = next_count(exp_q_q, mon.m_cl, mon.m_en, mon.m_ud);
        if (mismatch) begin
          fail_d = 1'b1;
          if (err_cnt_q != '1)
            err_cnt_d = err_cnt_q + EW'(1);
`ifdef COUNTER_CHECKER_RESYNC_EN
          // Follow the observed value so one glitch costs a single error.
          exp_q_d = next_count(mon.m_q, mon.m_cl, mon.m_en, mon.m_ud);
`endif
        end
      end
      default: begin
        state_d  = UNSYNC;
        synced_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (cl) begin
      state_q   <= UNSYNC;
      synced_q  <= 1'b0;
      mism_q    <= 1'b0;
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
      exp_q_q   <= '0;
    end else begin
      state_q   <= state_d;
      synced_q  <= synced_d;
      mism_q    <= mism_d;
      fail_q    <= fail_d;
      err_cnt_q <= err_cnt_d;
      exp_q_q   <= exp_q_d;
    end
  end

  assign synced  = synced_q;
  assign mism    = mism_q;
  assign fail    = fail_q;
  assign err_cnt = err_cnt_q;
  assign exp_q   = exp_q_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker (W=4, EW=8); the bench plays the observed counter.
module tb_counter_checker;

  logic       ck = 1'b0;
  logic       cl;
  logic       synced, mism, fail;
  logic [7:0] err_cnt;
  logic [3:0] exp_q;

  logic [3:0] cnt;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc_no   = 0;

  counter_checker_if #(.W(4)) bus ();

  counter_checker #(.W(4), .EW(8)) dut (
    .ck      (ck),
    .cl      (cl),
    .mon     (bus),
    .synced  (synced),
    .mism    (mism),
    .fail    (fail),
    .err_cnt (err_cnt),
    .exp_q   (exp_q)
  );

  always #5 ck = ~ck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // One counter cycle: present q/c, let the edge pass, then advance the bench counter.
  task automatic cyc(input logic clr, input logic en, input logic ud,
                     input logic c_frc, input logic c_val);
    bus.m_cl = clr;
    bus.m_en = en;
    bus.m_ud = ud;
    bus.m_q  = cnt;
    bus.m_c  = c_frc ? c_val : (en & (ud ? (cnt == 4'd0) : (cnt == 4'd15)));
    @(posedge ck);
    #1;
    if (clr)     cnt = 4'd0;
    else if (en) cnt = ud ? cnt - 4'd1 : cnt + 4'd1;
    cyc_no++;
    $display("cyc %0d: cl=%0b en=%0b ud=%0b q_in=%0d -> synced=%0b mism=%0b fail=%0b err_cnt=%0d exp_q=%0d",
             cyc_no, clr, en, ud, bus.m_q, synced, mism, fail, err_cnt, exp_q);
  endtask

  localparam logic [3:0] DOWN_EXP [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12};

`ifdef COUNTER_CHECKER_RESYNC_EN
  localparam int         E2 = 1, E3 = 1, ECL = 1;
  localparam logic [3:0] X1 = 4'd10, X2 = 4'd11, X3 = 4'd12;
  localparam logic       M2 = 1'b0, M3 = 1'b0, MCL = 1'b0;
`else
  localparam int         E2 = 2, E3 = 3, ECL = 4;
  localparam logic [3:0] X1 = 4'd6, X2 = 4'd7, X3 = 4'd8;
  localparam logic       M2 = 1'b1, M3 = 1'b1, MCL = 1'b1;
`endif

  initial begin
    cl = 1'b1;
    cnt = 4'd7;
    bus.m_cl = 1'b0; bus.m_en = 1'b0; bus.m_ud = 1'b0; bus.m_q = 4'd0; bus.m_c = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check_val("rst_synced", synced, 0);
    check_val("rst_mism", mism, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_err", err_cnt, 0);
    check_val("rst_exp_q", exp_q, 0);
    cl = 1'b0;

    // Garbage before any observed clear must be ignored.
    for (int i = 0; i < 5; i++) begin
      cnt = 4'($urandom_range(0, 15));
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      check_val("unsync_mism", mism, 0);
      check_val("unsync_synced", synced, 0);
    end
    check_val("unsync_err", err_cnt, 0);

    // Sync on m_cl, then count up through the wrap.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("sync_synced", synced, 1);
    check_val("sync_exp_q", exp_q, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("up_mism", mism, 0);
      check_val("up_exp_q", exp_q, (i + 1) % 16);
    end
    check_val("up_err", err_cnt, 0);

    // Count down from 4 through the 0 -> 15 wrap.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("down_mism", mism, 0);
      check_val("down_exp_q", exp_q, DOWN_EXP[i]);
    end
    check_val("down_fail", fail, 0);

    // Clear (compared normally), count to 5, then the counter jumps to 9.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("clr_mism", mism, 0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre_glitch_exp_q", exp_q, 5);
    cnt = 4'd9;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("glitch_mism", mism, 1);
    check_val("glitch_fail", fail, 1);
    check_val("glitch_err", err_cnt, 1);
    check_val("glitch_exp_q", exp_q, X1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("after1_mism", mism, M2);
    check_val("after1_err", err_cnt, E2);
    check_val("after1_exp_q", exp_q, X2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("after2_mism", mism, M3);
    check_val("after2_err", err_cnt, E3);
    check_val("after2_exp_q", exp_q, X3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("clr2_mism", mism, MCL);
    check_val("clr2_err", err_cnt, ECL);
    check_val("clr2_exp_q", exp_q, 0);
    check_val("clr2_fail", fail, 1);

    // Count to 15, then the counter fails to raise c.
    repeat (15) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre_c_mism", mism, 0);
    check_val("pre_c_exp_q", exp_q, 15);
    check_val("pre_c_err", err_cnt, ECL);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("c_mism", mism, 1);
    check_val("c_err", err_cnt, ECL + 1);
    check_val("c_exp_q", exp_q, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("post_c_mism", mism, 0);
    check_val("post_c_exp_q", exp_q, 1);

    // 300 cycles with a bogus end-of-count flag drive err_cnt into saturation.
    repeat (300) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("sat_err", err_cnt, 255);
    check_val("sat_fail", fail, 1);
    check_val("sat_mism", mism, 1);
    cl = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cl = 1'b0;
    check_val("mid_rst_synced", synced, 0);
    check_val("mid_rst_mism", mism, 0);
    check_val("mid_rst_fail", fail, 0);
    check_val("mid_rst_err", err_cnt, 0);
    check_val("mid_rst_exp_q", exp_q, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("mid_rst_unsync_mism", mism, 0);
    check_val("mid_rst_unsync_synced", synced, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
